// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU result source, load-result source and the
// register-file write port, plus FIFO occupancy.
interface writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic [4:0]               alu_rd;
  logic [31:0]              alu_data;
  logic                     alu_stall;
  logic                     lsu_valid;
  logic [4:0]               lsu_rd;
  logic [31:0]              lsu_data;
  logic                     lsu_ready;
  logic [4:0]               A3;
  logic [31:0]              WD3;
  logic                     WE3;
  logic [$clog2(DEPTH):0]   fifo_count;

  // Driven by the producers/consumer surrounding the arbiter
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_stall, lsu_ready, A3, WD3, WE3, fifo_count
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_stall, lsu_ready, A3, WD3, WE3, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges ALU results and queued load
// results onto one registered write port. ALU has priority unless the
// load FIFO head has been starved for STARVE_MAX consecutive cycles.
module writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               Async_reset,
  writeback_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO
  } sel_e;

  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [4:0]    r_a3;
  logic [31:0]   r_wd3;
  logic          r_we3;

  logic          w_empty;
  logic          w_full;
  logic          w_force;
  logic          w_alu_req;
  logic          w_push;
  logic          w_pop;
  sel_e          w_sel;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_force   = (r_starve == SW'(STARVE_MAX));
  assign w_alu_req = bus.alu_valid && (bus.alu_rd != 5'd0);
  // Loads to x0 complete the handshake but are never stored
  assign w_push    = bus.lsu_valid && !w_full && (bus.lsu_rd != 5'd0);
  assign w_pop     = (w_sel == SEL_FIFO);

  assign bus.lsu_ready  = !w_full;
  assign bus.alu_stall  = w_alu_req && w_force && !w_empty;
  assign bus.fifo_count = r_count;
  assign bus.A3         = r_a3;
  assign bus.WD3        = r_wd3;
  assign bus.WE3        = r_we3;

  // Per-cycle winner: starved FIFO head, else ALU, else FIFO head
  always_comb begin
    w_sel = SEL_NONE;
    if (w_force && !w_empty) begin
      w_sel = SEL_FIFO;
    end else if (w_alu_req) begin
      w_sel = SEL_ALU;
    end else if (!w_empty) begin
      w_sel = SEL_FIFO;
    end
  end

  // FIFO storage; contents need no reset since the pointers discard them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= bus.lsu_rd;
      r_mem_data[r_wptr] <= bus.lsu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge Async_reset) begin
    if (!Async_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: counts ALU wins over a waiting FIFO head
  always_ff @(posedge clk or negedge Async_reset) begin
    if (!Async_reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if ((w_sel == SEL_ALU) && !w_force) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Registered write port; address/data hold when nothing wins
  always_ff @(posedge clk or negedge Async_reset) begin
    if (!Async_reset) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else begin
      r_we3 <= (w_sel != SEL_NONE);
      case (w_sel)
        SEL_ALU: begin
          r_a3  <= bus.alu_rd;
          r_wd3 <= bus.alu_data;
        end
        SEL_FIFO: begin
          r_a3  <= r_mem_rd[r_rptr];
          r_wd3 <= r_mem_data[r_rptr];
        end
        default: begin
          r_a3  <= r_a3;
          r_wd3 <= r_wd3;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter. Expected register-file writes are
// queued in issue order as stimulus is driven; a negedge monitor pops and
// compares every WE3 pulse.
module tb_writeback_arbiter;

  localparam logic [31:0] D9 = 32'h9999_0009;

  logic clk;
  logic Async_reset;

  writeback_arbiter_if #(.DEPTH(4)) bus ();

  writeback_arbiter #(
    .DEPTH      (4),
    .STARVE_MAX (3)
  ) dut (
    .clk         (clk),
    .Async_reset (Async_reset),
    .bus         (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   vectors    = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = d;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every write must be the next expected one
  always @(negedge clk) begin
    if (bus.WE3 === 1'b1) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: got rd=%0d data=%0h want no write", bus.A3, bus.WD3);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        vectors++;
        assert ({bus.A3, bus.WD3} === {mon_e.rd, mon_e.data}) else begin
          miscompares++;
          $error("FAIL sb_write: got rd=%0d data=%0h want rd=%0d data=%0h",
                 bus.A3, bus.WD3, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    logic        acc;
    int          li;
    logic [4:0]  pp_rd [12];
    logic [31:0] pp_d  [12];

    Async_reset = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
    #12;
    // Reset state
    chk("rst_we3",   32'(bus.WE3), 32'd0);
    chk("rst_a3",    32'(bus.A3), 32'd0);
    chk("rst_wd3",   bus.WD3, 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ready", 32'(bus.lsu_ready), 32'd1);
    chk("rst_stall", 32'(bus.alu_stall), 32'd0);
    Async_reset = 1'b1;
    step();

    // ALU alone: one-cycle latency, then idle holds A3/WD3
    set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    push_exp(5'd5, 32'hDEAD_BEEF);
    step();
    chk("alu_we3", 32'(bus.WE3), 32'd1);
    chk("alu_a3",  32'(bus.A3), 32'd5);
    chk("alu_wd3", bus.WD3, 32'hDEAD_BEEF);
    set_alu(1'b0, 5'd0, 32'd0);
    step();
    chk("idle_we3", 32'(bus.WE3), 32'd0);
    chk("idle_a3",  32'(bus.A3), 32'd5);
    chk("idle_wd3", bus.WD3, 32'hDEAD_BEEF);

    // x0 destinations: consumed/accepted, never written or queued
    set_alu(1'b1, 5'd0, 32'h0000_1234);
    set_lsu(1'b1, 5'd0, 32'h0000_5678);
    #1;
    chk("x0_stall", 32'(bus.alu_stall), 32'd0);
    chk("x0_ready", 32'(bus.lsu_ready), 32'd1);
    step();
    chk("x0_we3",   32'(bus.WE3), 32'd0);
    chk("x0_count", 32'(bus.fifo_count), 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
    step();
    chk("x0_we3b", 32'(bus.WE3), 32'd0);

    // Starvation: one queued load against continuous ALU rd=7
    set_lsu(1'b1, 5'd3, 32'h3333_0003);
    step();
    set_lsu(1'b0, 5'd0, 32'd0);
    chk("stv_count", 32'(bus.fifo_count), 32'd1);
    push_exp(5'd7, 32'h7777_0007);
    push_exp(5'd7, 32'h7777_0007);
    push_exp(5'd7, 32'h7777_0007);
    push_exp(5'd3, 32'h3333_0003);
    push_exp(5'd7, 32'h7777_0007);
    set_alu(1'b1, 5'd7, 32'h7777_0007);
    #1;
    chk("stv_stall0", 32'(bus.alu_stall), 32'd0);
    step();
    chk("stv_stall1", 32'(bus.alu_stall), 32'd0);
    step();
    chk("stv_stall2", 32'(bus.alu_stall), 32'd0);
    step();
    chk("stv_stall3", 32'(bus.alu_stall), 32'd1);
    chk("stv_a3_alu", 32'(bus.A3), 32'd7);
    step();
    chk("stv_a3_ld",  32'(bus.A3), 32'd3);
    chk("stv_wd3_ld", bus.WD3, 32'h3333_0003);
    chk("stv_cnt0",   32'(bus.fifo_count), 32'd0);
    chk("stv_stallx", 32'(bus.alu_stall), 32'd0);
    step();
    chk("stv_a3_post",  32'(bus.A3), 32'd7);
    chk("stv_wd3_post", bus.WD3, 32'h7777_0007);
    chk("stv_we3_post", 32'(bus.WE3), 32'd1);
    set_alu(1'b0, 5'd0, 32'd0);
    step();
    chk("stv_we3_end", 32'(bus.WE3), 32'd0);

    // FIFO full: 5 loads with ALU rd=9 valid for 20 edges
    for (int e = 1; e <= 21; e++) begin
      if (e >= 5 && (e % 4) == 1) push_exp(5'((e - 1) / 4), 32'h1000_0000 + 32'((e - 1) / 4));
      else                        push_exp(5'd9, D9);
    end
    li = 1;
    for (int c = 1; c <= 21; c++) begin
      set_alu(c <= 20, 5'd9, D9);
      if (li <= 5) set_lsu(1'b1, 5'(li), 32'h1000_0000 + 32'(li));
      else         set_lsu(1'b0, 5'd0, 32'd0);
      #1;
      if (c == 5) chk("full_stall", 32'(bus.alu_stall), 32'd1);
      acc = bus.lsu_valid && bus.lsu_ready;
      step();
      if (acc) li++;
      if (c == 4) begin
        chk("full_ready", 32'(bus.lsu_ready), 32'd0);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
      end
      if (c == 6) chk("full_count6", 32'(bus.fifo_count), 32'd4);
    end
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
    chk("full_accepts", 32'(li), 32'd6);
    chk("full_drained", 32'(bus.fifo_count), 32'd0);

    // Simultaneous push/pop at count 2, streaming 12 loads through the wrap
    for (int i = 0; i < 12; i++) begin
      pp_rd[i] = 5'(i + 1);
      pp_d[i]  = $urandom;
    end
    push_exp(5'd9, D9);
    push_exp(5'd9, D9);
    for (int i = 0; i < 12; i++) push_exp(pp_rd[i], pp_d[i]);
    set_alu(1'b1, 5'd9, D9);
    set_lsu(1'b1, pp_rd[0], pp_d[0]);
    step();
    set_lsu(1'b1, pp_rd[1], pp_d[1]);
    step();
    chk("pp_pre", 32'(bus.fifo_count), 32'd2);
    set_alu(1'b0, 5'd0, 32'd0);
    for (int i = 2; i < 12; i++) begin
      set_lsu(1'b1, pp_rd[i], pp_d[i]);
      step();
      chk("pp_count", 32'(bus.fifo_count), 32'd2);
    end
    set_lsu(1'b0, 5'd0, 32'd0);
    step();
    chk("pp_drain1", 32'(bus.fifo_count), 32'd1);
    step();
    chk("pp_drain0", 32'(bus.fifo_count), 32'd0);
    step();

    // Reset mid-operation with 3 loads queued behind the ALU
    push_exp(5'd9, D9);
    push_exp(5'd9, D9);
    push_exp(5'd9, D9);
    set_alu(1'b1, 5'd9, D9);
    for (int i = 0; i < 3; i++) begin
      set_lsu(1'b1, 5'(20 + i), 32'hAAAA_0000 + 32'(i));
      step();
    end
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
    chk("mr_count3", 32'(bus.fifo_count), 32'd3);
    @(negedge clk);
    #1;
    Async_reset = 1'b0;
    #1;
    chk("mr_we3",   32'(bus.WE3), 32'd0);
    chk("mr_a3",    32'(bus.A3), 32'd0);
    chk("mr_wd3",   bus.WD3, 32'd0);
    chk("mr_count", 32'(bus.fifo_count), 32'd0);
    chk("mr_ready", 32'(bus.lsu_ready), 32'd1);
    chk("mr_stall", 32'(bus.alu_stall), 32'd0);
    #1;
    Async_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mr_post_we3",   32'(bus.WE3), 32'd0);
      chk("mr_post_count", 32'(bus.fifo_count), 32'd0);
    end

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the load-result FIFO depth in entries; legal values are powers of two, 2..16.
REQ-002 Parameter STARVE_MAX, default 3, SHALL set the number of consecutive cycles the FIFO head can lose to the ALU before it is forced through.
REQ-003 Ports SHALL be as follows, one per line, as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on rising edge.
- Async_reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU result not consumed this cycle; source holds alu_valid, alu_rd and alu_data.
- lsu_valid  in  1  load result present.
- lsu_rd  in  5  load destination register.
- lsu_data  in  32  load data.
- lsu_ready  out  1  FIFO can accept; a load transfer occurs when lsu_valid and lsu_ready are both high at a rising edge.
- A3  out  5  register-file write address (registered).
- WD3  out  32  register-file write data (registered).
- WE3  out  1  register-file write enable (registered).
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-004 The block SHALL drive the register file's single write port from two sources, ALU and load unit, producing at most one write per cycle.
REQ-005 Load results SHALL be enqueued into a DEPTH-entry FIFO of {rd, data}.
REQ-006 A load with lsu_rd==0 SHALL be accepted (handshake completes) but not enqueued.
REQ-007 An ALU result with alu_rd==0 SHALL be consumed with no write and SHALL NOT cause alu_stall.
REQ-008 lsu_ready SHALL equal (fifo_count != DEPTH), computed from registered state only; a pop in the same cycle SHALL NOT raise lsu_ready.
REQ-009 Arbitration per cycle SHALL be: if force is active and the FIFO is non-empty, the FIFO head wins; else a valid ALU result with nonzero rd wins; else a non-empty FIFO head wins; else no write.
REQ-010 force SHALL be (starve_cnt == STARVE_MAX).
REQ-011 alu_stall SHALL equal (alu_valid && alu_rd!=0 && force && FIFO non-empty), combinationally.
REQ-012 starve_cnt SHALL increment, saturating at STARVE_MAX, in each cycle the FIFO is non-empty and the ALU wins.
REQ-013 starve_cnt SHALL clear to 0 on any FIFO pop and in any cycle the FIFO is empty.
REQ-014 The winner SHALL be registered onto A3/WD3/WE3 at the next rising edge, giving 1-cycle latency from ALU sample to WE3.
REQ-015 With no winner, WE3 SHALL be 0 and A3/WD3 SHALL hold their previous values.
REQ-016 A load accepted at edge N SHALL be poppable no earlier than the cycle after edge N (no FIFO bypass), so WE3 rises at edge N+1 at the earliest.
REQ-017 The FIFO head SHALL be popped at the same edge its write is registered.
REQ-018 When push and pop occur in the same edge, fifo_count SHALL be unchanged.
REQ-019 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-020 Writes SHALL leave in FIFO order; ordering between ALU and load writes to the same rd is the issuing pipeline's responsibility and SHALL NOT be checked.

Reset
REQ-021 On Async_reset low, the block SHALL asynchronously clear WE3=0, A3=0, WD3=0, fifo_count=0, both pointers=0 and starve_cnt=0.
REQ-022 FIFO contents SHALL be discarded on reset, including mid-operation.
REQ-023 While Async_reset is low, lsu_ready SHALL be 1 and alu_stall SHALL be 0.
REQ-024 The first write after reset release SHALL require a fresh request.

Verification
REQ-025 ALU alone: alu_valid=1, rd=5, data=0xDEADBEEF at edge 1 -> A3=5, WD3=0xDEADBEEF, WE3=1 after edge 1; WE3=0 after edge 2 with no request.
REQ-026 x0 drop: alu_rd=0, and a load with lsu_rd=0 accepted -> WE3 stays 0, fifo_count stays 0, alu_stall=0.
REQ-027 FIFO full: with DEPTH=4, 5 back-to-back loads (rd=1..5) while the ALU is valid every cycle with rd=9 -> lsu_ready=0 after the 4th accept; writes appear later in order rd 1,2,3,4,5.
REQ-028 Starvation: 1 load queued plus continuous ALU (rd=7) -> ALU wins 3 cycles; 4th cycle alu_stall=1, load written, ALU written the next cycle with unchanged data.
REQ-029 Simultaneous push and pop at fifo_count=2 -> fifo_count remains 2; pointer wrap exercised over 10+ entries with data integrity checked.
REQ-030 Reset mid-operation: 3 loads queued, Async_reset pulsed low between edges -> outputs 0 immediately, fifo_count=0, and no queued write appears after release.
